keypad_scanner: RTL

Parametrised matrix-keypad scanner and debouncer, the successor to the fixed 4x4 numpad decoder. It drives the keypad columns itself, samples the rows through a synchroniser, and rejects frames with ghosting or multiple keys. It debounces the result over whole scan frames and presents the held key as a one-hot vector, a binary code and press/release strobes. It feeds the mole logic and any future menu/score-entry logic.

---
 rtl/keypad_scanner.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix-keypad column scanner with a row synchroniser,
// frame-level ghost/multi-key rejection and frame-based debounce.
//
// Ports:
//   clk            master clock
//   rst            asynchronous active-high reset
//   cols_out       column drive, active-low, one column low at a time
//   rows_in        row sense, active-low, asynchronous to clk
//   key_states     one-hot held key (bit = row*COLS + col), zero when none
//   key_code       binary index of held key; keeps last value on release
//   key_valid      high while a debounced key is held
//   press_pulse    one-cycle strobe when a new key is accepted
//   release_pulse  one-cycle strobe when the held key is dropped
module keypad_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [COLS-1:0]              cols_out,
    input  logic [ROWS-1:0]              rows_in,
    output logic [ROWS*COLS-1:0]         key_states,
    output logic [$clog2(ROWS*COLS)-1:0] key_code,
    output logic                         key_valid,
    output logic                         press_pulse,
    output logic                         release_pulse
);

    localparam int NK = ROWS * COLS;
    localparam int KW = $clog2(NK);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_FRAMES);

    typedef enum logic {S_IDLE, S_HELD} state_t;
    typedef enum logic [1:0] {F_NONE, F_SINGLE, F_MULTI} frame_kind_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [CW-1:0]   col_q, col_d;
    logic [COLS-1:0] cols_q, cols_d;
    logic [ROWS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NK-1:0]   acc_q, acc_d;
    frame_kind_t     prev_kind_q, prev_kind_d;
    logic [KW-1:0]   prev_key_q, prev_key_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NK-1:0]   key_states_q, key_states_d;
    logic [KW-1:0]   key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    logic            sample, frame_end;
    logic [NK-1:0]   frame_v;
    frame_kind_t     kind;
    logic [KW-1:0]   fkey;
    logic            found;

    // Scan timing and frame accumulation
    always_comb begin
        sync1_d   = rows_in;
        sync2_d   = sync1_q;
        sample    = (div_q == DW'(SCAN_DIV - 1));
        frame_end = sample && (col_q == CW'(COLS - 1));
        div_d     = sample ? '0 : div_q + DW'(1);
        col_d     = col_q;
        if (sample) begin
            col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
        end
        // Drive follows the next column so cols_out is a clean register.
        cols_d = '1;
        for (int c = 0; c < COLS; c++) begin
            if (col_d == CW'(c)) cols_d[c] = 1'b0;
        end
        // Current column's sample is folded in so the frame-end column counts.
        frame_v = acc_q;
        if (sample) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (col_q == CW'(c) && !sync2_q[r]) frame_v[r*COLS+c] = 1'b1;
                end
            end
        end
        acc_d = frame_end ? '0 : frame_v;
    end

    // Frame classification: none / single(k) / multi
    always_comb begin
        found = 1'b0;
        kind  = F_NONE;
        fkey  = '0;
        for (int i = 0; i < NK; i++) begin
            if (frame_v[i]) begin
                kind  = found ? F_MULTI : F_SINGLE;
                found = 1'b1;
                fkey  = KW'(i);
            end
        end
    end

    // Debounce FSM next-state and registered outputs
    always_comb begin
        state_d     = state_q;
        prev_kind_d = prev_kind_q;
        prev_key_d  = prev_key_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        if (frame_end) begin
            if (kind == F_MULTI) begin
                cnt_d = 4'd0;
            end else if (kind == prev_kind_q && (kind == F_NONE || fkey == prev_key_q)) begin
                cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
            end else begin
                cnt_d = 4'd1;
            end
            prev_kind_d = kind;
            prev_key_d  = fkey;
            if (cnt_d == CNT_MAX) begin
                case (state_q)
                    S_IDLE: if (kind == F_SINGLE) begin
                        state_d    = S_HELD;
                        key_code_d = fkey;
                        press_d    = 1'b1;
                    end
                    S_HELD: if (kind == F_NONE) begin
                        state_d   = S_IDLE;
                        release_d = 1'b1;
                    end else if (kind == F_SINGLE && fkey != key_code_q) begin
                        // Roll-over: drop the old key and accept the new one together.
                        key_code_d = fkey;
                        press_d    = 1'b1;
                        release_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        key_valid_d = (state_d == S_HELD);
        for (int i = 0; i < NK; i++) begin
            key_states_d[i] = (state_d == S_HELD) && (key_code_d == KW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            col_q        <= '0;
            cols_q       <= '1;
            sync1_q      <= '1;
            sync2_q      <= '1;
            acc_q        <= '0;
            prev_kind_q  <= F_NONE;
            prev_key_q   <= '0;
            cnt_q        <= '0;
            key_states_q <= '0;
            key_code_q   <= '0;
            key_valid_q  <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            col_q        <= col_d;
            cols_q       <= cols_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            acc_q        <= acc_d;
            prev_kind_q  <= prev_kind_d;
            prev_key_q   <= prev_key_d;
            cnt_q        <= cnt_d;
            key_states_q <= key_states_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
            press_q      <= press_d;
            release_q    <= release_d;
        end
    end

    assign cols_out      = cols_q;
    assign key_states    = key_states_q;
    assign key_code      = key_code_q;
    assign key_valid     = key_valid_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule
